// File: rtl/pong_match_sequencer_pkg.sv
// Shared constants for the Pong match controller: state encoding and datapath widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pong_pkg;

  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 8;

  // Codes are shown on screen, so the numeric values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_POINT      = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_e;

endpackage

// File: rtl/pong_match_sequencer_if.sv
// Player-side pulses in, datapath/display controls out, bundled for the match sequencer.
// Latency: wires only.
// Backpressure: none; all inputs are single-cycle pulses that are never stalled.
// Ports: slave = sequencer side (pulses in, controls out); master = driver/observer side.
interface pong_match_sequencer_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               start;
  logic               pause;
  logic               miss_left;
  logic               miss_right;
  logic               ball_run;
  logic               ball_center;
  logic               launch;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start, pause, miss_left, miss_right,
    input  ball_run, ball_center, launch, serve_dir,
    input  score_left, score_right, winner, state
  );

  modport slave (
    input  frame_tick, start, pause, miss_left, miss_right,
    output ball_run, ball_center, launch, serve_dir,
    output score_left, score_right, winner, state
  );

endinterface

// File: rtl/pong_match_sequencer_frame_countdown.sv
// Loadable down-counter of frame ticks; zero_o flags an expired delay.
// Latency: load/decrement visible one cycle after the request.
// Backpressure: none; load wins over tick, tick is ignored once at zero.
// Ports: clk, rst_n, load_i, load_value_i[W], tick_i -> zero_o.
module frame_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pong_match_sequencer.sv
// Pong match FSM: serve/point delays in frames, scoring, pause, winner; drives ball control.
// Latency: every output is registered; actions land on the edge that samples the pulse.
// Backpressure: none; pulses with no transition in the current state are dropped.
// Ports: clk, rst_n (async, active-low), bus (slave modport of pong_match_sequencer_if).
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE          = 9,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned POINT_PAUSE_FRAMES = 90
) (
  input logic                  clk,
  input logic                  rst_n,
  pong_match_sequencer_if.slave bus
);

  localparam logic [SCORE_W:0]       WIN_V   = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_V = FRAME_CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] POINT_V = FRAME_CNT_W'(POINT_PAUSE_FRAMES);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               launch_q, launch_d;
  logic               run_q, run_d;
  logic               center_q, center_d;
  // Low for the first edge after reset release so no transition fires on it.
  logic               armed_q;

  logic                   cnt_load;
  logic [FRAME_CNT_W-1:0] cnt_val;
  logic                   cnt_tick;
  logic                   cnt_zero;

  // One extra bit so the comparison against WIN_SCORE cannot wrap.
  logic [SCORE_W:0] inc_l, inc_r;
  assign inc_l = {1'b0, score_l_q} + (SCORE_W+1)'(1);
  assign inc_r = {1'b0, score_r_q} + (SCORE_W+1)'(1);

  frame_countdown #(.W(FRAME_CNT_W)) u_countdown (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (cnt_load),
    .load_value_i (cnt_val),
    .tick_i       (cnt_tick),
    .zero_o       (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    cnt_load    = 1'b0;
    cnt_val     = SERVE_V;
    cnt_tick    = 1'b0;

    if (armed_q) begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (bus.start) begin
            state_d     = ST_SERVE_WAIT;
            score_l_d   = '0;
            score_r_d   = '0;
            serve_dir_d = 1'b0;
            cnt_load    = 1'b1;
            cnt_val     = SERVE_V;
          end
        end
        ST_SERVE_WAIT: begin
          // Counter holds at zero, so the exiting tick never decrements it.
          cnt_tick = bus.frame_tick;
          if (bus.frame_tick && cnt_zero) begin
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Misses outrank pause; a pause in the same cycle is simply lost.
          if (bus.miss_left && bus.miss_right) begin
            state_d  = ST_POINT;
            cnt_load = 1'b1;
            cnt_val  = POINT_V;
          end else if (bus.miss_left) begin
            score_r_d   = inc_r[SCORE_W-1:0];
            serve_dir_d = 1'b1;
            if (inc_r == WIN_V) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d  = ST_POINT;
              cnt_load = 1'b1;
              cnt_val  = POINT_V;
            end
          end else if (bus.miss_right) begin
            score_l_d   = inc_l[SCORE_W-1:0];
            serve_dir_d = 1'b0;
            if (inc_l == WIN_V) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b0;
            end else begin
              state_d  = ST_POINT;
              cnt_load = 1'b1;
              cnt_val  = POINT_V;
            end
          end else if (bus.pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (bus.pause) begin
            state_d = ST_PLAY;
          end
        end
        ST_POINT: begin
          cnt_tick = bus.frame_tick;
          if (bus.frame_tick && cnt_zero) begin
            state_d  = ST_SERVE_WAIT;
            cnt_load = 1'b1;
            cnt_val  = SERVE_V;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Ball controls follow the next state so they line up with state_q.
    run_d    = (state_d == ST_PLAY);
    center_d = (state_d == ST_IDLE) || (state_d == ST_SERVE_WAIT) ||
               (state_d == ST_POINT) || (state_d == ST_GAME_OVER);
    // Resuming from PAUSED must not re-serve, so only SERVE_WAIT->PLAY launches.
    launch_d = (state_q == ST_SERVE_WAIT) && (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      launch_q    <= 1'b0;
      run_q       <= 1'b0;
      center_q    <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      launch_q    <= launch_d;
      run_q       <= run_d;
      center_q    <= center_d;
      armed_q     <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.winner      = winner_q;
  assign bus.launch      = launch_q;
  assign bus.ball_run    = run_q;
  assign bus.ball_center = center_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer with WIN_SCORE=3, SERVE=2, POINT=1.
// Each predicted output change is queued; the monitor pops one per observed change.
// Async reset is additionally checked directly before any clock edge.
module tb_pong_match_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       sd;
    logic       win;
    logic       la;
    logic       run;
    logic       ctr;
  } snap_t;

  logic clk;
  logic rst_n;

  pong_match_sequencer_if bus();

  pong_match_sequencer #(
    .WIN_SCORE          (3),
    .SERVE_DELAY_FRAMES (2),
    .POINT_PAUSE_FRAMES (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  snap_t exp_q[$];
  string tag_q[$];

  function automatic snap_t cur();
    snap_t s;
    s.st  = bus.state;
    s.sl  = bus.score_left;
    s.sr  = bus.score_right;
    s.sd  = bus.serve_dir;
    s.win = bus.winner;
    s.la  = bus.launch;
    s.run = bus.ball_run;
    s.ctr = bus.ball_center;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d sl=%0d sr=%0d sd=%b win=%b launch=%b run=%b center=%b",
                     s.st, s.sl, s.sr, s.sd, s.win, s.la, s.run, s.ctr);
  endfunction

  task automatic ex(input string tag, input logic [2:0] st, input logic [3:0] sl,
                    input logic [3:0] sr, input logic sd, input logic win,
                    input logic la, input logic run, input logic ctr);
    snap_t s;
    s = '{st: st, sl: sl, sr: sr, sd: sd, win: win, la: la, run: run, ctr: ctr};
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  // Monitor: any change of the observable outputs must match the next prediction.
  initial begin
    snap_t prev, s, e;
    string t;
    bit    have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      s = cur();
      if (!have || (s !== prev)) begin
        have = 1'b1;
        prev = s;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %s, required no change", fmt(s));
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (s !== e) begin
            n_bad++;
            $display("FAIL %s: got %s, required %s", t, fmt(s), fmt(e));
          end
        end
      end
    end
  end

  task automatic drv(input logic t, input logic s, input logic p,
                     input logic ml, input logic mr);
    @(posedge clk); #1;
    bus.frame_tick = t;
    bus.start      = s;
    bus.pause      = p;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Two more ticks drain a 2-frame serve count, the third launches.
  task automatic serve_to_play(input string tag, input logic [3:0] sl,
                               input logic [3:0] sr, input logic sd);
    ticks(2);
    ex({tag, "_launch"}, 3'd2, sl, sr, sd, 1'b0, 1'b1, 1'b1, 1'b0);
    ex({tag, "_run"},    3'd2, sl, sr, sd, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
  endtask

  // A scored point that does not end the match, then back to PLAY.
  task automatic point(input string tag, input bit left_missed, input logic [3:0] sl,
                       input logic [3:0] sr, input logic sd);
    ex({tag, "_point"}, 3'd4, sl, sr, sd, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, left_missed, !left_missed);
    ticks(1);
    ex({tag, "_serve"}, 3'd1, sl, sr, sd, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(1);
    serve_to_play(tag, sl, sr, sd);
  endtask

  task automatic async_reset(input string tag);
    snap_t r, s;
    r = '{st: 3'd0, sl: 4'd0, sr: 4'd0, sd: 1'b0, win: 1'b0, la: 1'b0, run: 1'b0, ctr: 1'b1};
    ex(tag, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    s = cur();
    n_cmp++;
    if (s !== r) begin
      n_bad++;
      $display("FAIL %s_async: got %s, required %s", tag, fmt(s), fmt(r));
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    ex("reset", 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // First serve; pause and misses in SERVE_WAIT are ignored.
    ex("start", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(1);
    serve_to_play("first", 4'd0, 4'd0, 1'b0);

    // Simultaneous misses: no score, serve_dir stays 0.
    ex("both_point", 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ticks(1);
    ex("both_serve", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(1);
    serve_to_play("both", 4'd0, 4'd0, 1'b0);

    // Left misses: right scores, serve toward the left.
    point("miss_l", 1'b1, 4'd0, 4'd1, 1'b1);

    // Pause freezes; misses, ticks and start are ignored; resume has no launch.
    ex("pause", 3'd3, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex("resume", 3'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Miss beats pause in the same cycle; stray pause in POINT is ignored.
    ex("mr_pause_point", 3'd4, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    ex("mr_pause_serve", 3'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(1);
    serve_to_play("mr_pause", 4'd1, 4'd1, 1'b0);

    point("mr2", 1'b0, 4'd2, 4'd1, 1'b0);
    ex("win_left", 3'd5, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Restart; a tick coincident with start must not count.
    ex("restart", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    serve_to_play("restart", 4'd0, 4'd0, 1'b0);
    point("ml1", 1'b1, 4'd0, 4'd1, 1'b1);
    point("ml2", 1'b1, 4'd0, 4'd2, 1'b1);
    ex("win_right", 3'd5, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    async_reset("rst_game_over");

    // Reset while paused.
    ex("start2", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    serve_to_play("start2", 4'd0, 4'd0, 1'b0);
    ex("pause2", 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    async_reset("rst_paused");

    // Reset in the middle of a point pause.
    ex("start3", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    serve_to_play("start3", 4'd0, 4'd0, 1'b0);
    ex("point3", 3'd4, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(1);
    async_reset("rst_point");

    repeat (4) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predicted changes never seen, required 0 (next %s)",
               exp_q.size(), tag_q[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
